// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill controller.
// Holds the bus widths, the line geometry, the controller state encoding
// and a helper that picks one word out of an assembled line.
package icache_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 8;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int OFFSET_W   = 5;
  localparam int CNT_W      = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    WRITE  = 2'd3
  } state_e;

  // Word idx of a line; word 0 sits in the least significant bits.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [CNT_W-1:0]  idx);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (idx == i[CNT_W-1:0]) w = line[i*WORD_W +: WORD_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Bundle of every signal the refill controller exchanges with the fetch
// stage (cpu_*), the two-way group (cache_*) and instruction memory (mem_*).
//   master : the refill controller
//   slave  : the surrounding blocks (fetch stage, group, memory)
interface icache_refill_ctrl_if;
  import icache_pkg::*;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic [WORD_W-1:0] cpu_data;

  logic              cache_enable;
  logic              cache_compare;
  logic              cache_read;
  logic [ADDR_W-1:0] cache_address;
  logic [LINE_W-1:0] cache_line;
  logic              cache_hit;
  logic [WORD_W-1:0] cache_data;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_data;

  modport master (
    input  cpu_req, cpu_addr, cache_hit, cache_data, mem_ack, mem_data,
    output cpu_ready, cpu_data, cache_enable, cache_compare, cache_read,
           cache_address, cache_line, mem_req, mem_addr
  );

  modport slave (
    output cpu_req, cpu_addr, cache_hit, cache_data, mem_ack, mem_data,
    input  cpu_ready, cpu_data, cache_enable, cache_compare, cache_read,
           cache_address, cache_line, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_line_assembler.sv
// Collects the words of one cache line as memory returns them.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : restart a line (count and buffer back to zero)
//   wr_en_i       : store word_i at the current count and advance
//   word_i        : incoming memory word
//   cnt_o         : index of the next word to be stored
//   last_o        : the next stored word completes the line
//   line_o        : assembled line buffer
module icache_line_assembler
  import icache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              last_o,
  output logic [LINE_W-1:0] line_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_q, line_d;

  // The count wraps naturally; the controller leaves the refill on the
  // write that sees last_o, so the wrap is never used to overwrite word 0.
  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (clear_i) begin
      cnt_d  = '0;
      line_d = '0;
    end else if (wr_en_i) begin
      for (int i = 0; i < LINE_WORDS; i++) begin
        if (cnt_q == i[CNT_W-1:0]) line_d[i*WORD_W +: WORD_W] = word_i;
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(LINE_WORDS - 1));
  assign line_o = line_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller. Each fetch does one lookup in the
// two-way group; on a miss it reads a full line from memory word by word,
// writes it into the group in a single cycle and returns the requested word.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (master)  : cpu_* fetch handshake, cache_* group control/data,
//                   mem_* word-by-word memory read handshake
// All outputs come straight from registers.
module icache_refill_ctrl
  import icache_pkg::*;
(
  input logic                 clk_i,
  input logic                 rst_ni,
  icache_refill_ctrl_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic [WORD_W-1:0] cpu_data_q, cpu_data_d;
  logic              cache_enable_q, cache_enable_d;
  logic              cache_compare_q, cache_compare_d;
  logic              cache_read_q, cache_read_d;
  logic              mem_req_q, mem_req_d;

  logic              asm_clear;
  logic              asm_wr;
  logic [CNT_W-1:0]  asm_cnt;
  logic              asm_last;
  logic [LINE_W-1:0] asm_line;

  icache_line_assembler u_line_asm (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (asm_clear),
    .wr_en_i (asm_wr),
    .word_i  (bus.mem_data),
    .cnt_o   (asm_cnt),
    .last_o  (asm_last),
    .line_o  (asm_line)
  );

  // The *_d values are what the outputs show in the next state, so the
  // group control for a state is set up on the transition into it.
  // cache_read defaults high so the group's victim toggle only fires on
  // the single WRITE cycle of a real fill.
  always_comb begin
    state_d         = state_q;
    req_addr_d      = req_addr_q;
    cpu_data_d      = cpu_data_q;
    cpu_ready_d     = 1'b0;
    cache_enable_d  = 1'b0;
    cache_compare_d = 1'b0;
    cache_read_d    = 1'b1;
    mem_req_d       = 1'b0;
    asm_clear       = 1'b0;
    asm_wr          = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          req_addr_d      = bus.cpu_addr;
          cache_enable_d  = 1'b1;
          cache_compare_d = 1'b1;
          state_d         = LOOKUP;
        end
      end
      LOOKUP: begin
        if (bus.cache_hit) begin
          cpu_data_d  = bus.cache_data;
          cpu_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          asm_clear = 1'b1;
          mem_req_d = 1'b1;
          state_d   = REFILL;
        end
      end
      REFILL: begin
        mem_req_d = 1'b1;
        if (mem_req_q && bus.mem_ack) begin
          asm_wr = 1'b1;
          if (asm_last) begin
            mem_req_d      = 1'b0;
            cache_enable_d = 1'b1;
            cache_read_d   = 1'b0;
            state_d        = WRITE;
          end
        end
      end
      WRITE: begin
        cpu_data_d  = line_word(asm_line, req_addr_q[OFFSET_W-1:2]);
        cpu_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      req_addr_q      <= '0;
      cpu_ready_q     <= 1'b0;
      cpu_data_q      <= '0;
      cache_enable_q  <= 1'b0;
      cache_compare_q <= 1'b0;
      cache_read_q    <= 1'b1;
      mem_req_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_addr_q      <= req_addr_d;
      cpu_ready_q     <= cpu_ready_d;
      cpu_data_q      <= cpu_data_d;
      cache_enable_q  <= cache_enable_d;
      cache_compare_q <= cache_compare_d;
      cache_read_q    <= cache_read_d;
      mem_req_q       <= mem_req_d;
    end
  end

  assign bus.cpu_ready     = cpu_ready_q;
  assign bus.cpu_data      = cpu_data_q;
  assign bus.cache_enable  = cache_enable_q;
  assign bus.cache_compare = cache_compare_q;
  assign bus.cache_read    = cache_read_q;
  assign bus.cache_address = req_addr_q;
  assign bus.cache_line    = asm_line;
  assign bus.mem_req       = mem_req_q;
  // Word address inside the line follows the fill count directly.
  assign bus.mem_addr      = {req_addr_q[ADDR_W-1:OFFSET_W], asm_cnt, 2'b00};

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl. The bench plays fetch stage,
// two-way group and memory; memory contents live in an associative array
// and expected words/lines/latencies are derived from that image.
module tb_icache_refill_ctrl;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  icache_refill_ctrl_if bus ();

  icache_refill_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Memory image, word-address keyed, filled lazily with random words
  logic [31:0] memImage [logic [31:0]];
  int          memWait  = 0;
  int          waitCnt  = 0;
  bit          strayAck = 1'b0;
  logic [31:0] memAddrLog [$];

  // Monitor counters
  int          writeCycles  = 0;
  int          memReqCycles = 0;
  int          lookupCount  = 0;
  logic [31:0] lookupAddr   = '0;
  logic [LINE_W-1:0] lastLine = '0;

  function automatic logic [31:0] memRead(input logic [31:0] addr);
    logic [31:0] key;
    key = {addr[31:2], 2'b00};
    if (!memImage.exists(key)) memImage[key] = $urandom;
    return memImage[key];
  endfunction

  function automatic logic [LINE_W-1:0] expectedLine(input logic [31:0] addr);
    logic [LINE_W-1:0] line;
    logic [31:0] base;
    base = addr & 32'hFFFF_FFE0;
    for (int i = 0; i < LINE_WORDS; i++) line[i*32 +: 32] = memRead(base + 32'(i * 4));
    return line;
  endfunction

  // Memory responder and bus monitor, all on the falling edge
  always @(negedge clk) begin
    if (bus.cache_enable && !bus.cache_read) begin
      writeCycles++;
      lastLine = bus.cache_line;
    end
    if (bus.cache_enable && bus.cache_compare && bus.cache_read) begin
      lookupCount++;
      lookupAddr = bus.cache_address;
    end
    if (bus.mem_req) begin
      memReqCycles++;
      if (waitCnt >= memWait) begin
        bus.mem_ack  = 1'b1;
        bus.mem_data = memRead(bus.mem_addr);
        memAddrLog.push_back(bus.mem_addr);
        waitCnt = 0;
      end else begin
        bus.mem_ack  = 1'b0;
        bus.mem_data = $urandom;
        waitCnt++;
      end
    end else begin
      bus.mem_ack  = strayAck;
      bus.mem_data = 32'hBAD0_0000 | $urandom_range(0, 255);
      waitCnt = 0;
    end
  end

  // One fetch, started on a falling edge; latency counts falling edges
  // from the request cycle to the one showing cpu_ready.
  task automatic doFetch(input logic [31:0] addr, input bit hit, input logic [31:0] hitData,
                         output int latency, output logic [31:0] data);
    bus.cpu_req    = 1'b1;
    bus.cpu_addr   = addr;
    bus.cache_hit  = hit;
    bus.cache_data = hitData;
    latency = -1;
    data    = 'x;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      bus.cpu_req = 1'b0;
      if (bus.cpu_ready) begin
        latency = k;
        data    = bus.cpu_data;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cache_hit = 1'b0; bus.cache_data = '0;
    repeat (2) @(negedge clk);
    assertCount++;
    if ({bus.cpu_ready, bus.cache_enable, bus.cache_compare, bus.cache_read, bus.mem_req} !== 5'b00010) begin
      failCount++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 00010",
               {bus.cpu_ready, bus.cache_enable, bus.cache_compare, bus.cache_read, bus.mem_req});
    end
    assertCount++;
    if (bus.cpu_data !== 32'h0 || bus.cache_address !== 32'h0 || bus.mem_addr !== 32'h0) begin
      failCount++;
      $display("[TB] FAIL reset_data: cpu_data=%h cache_address=%h mem_addr=%h, expected all 0",
               bus.cpu_data, bus.cache_address, bus.mem_addr);
    end
    assertCount++;
    if (bus.cache_line !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_line: got %h, expected 0", bus.cache_line);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    assertCount++;
    if (lookupCount !== 0 || memReqCycles !== 0 || bus.cpu_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_idle: lookups=%0d memReqCycles=%0d cpu_ready=%b, expected 0/0/0",
               lookupCount, memReqCycles, bus.cpu_ready);
    end
  endtask

  task automatic test_hit();
    int lat; logic [31:0] data; int w0, r0, l0;
    w0 = writeCycles; r0 = memReqCycles; l0 = lookupCount;
    doFetch(32'h0000_1004, 1'b1, 32'hDEAD_BEEF, lat, data);
    assertCount++;
    if (lat !== 2) begin failCount++; $display("[TB] FAIL hit_latency: got %0d, expected 2", lat); end
    assertCount++;
    if (data !== 32'hDEAD_BEEF) begin failCount++; $display("[TB] FAIL hit_data: got %h, expected deadbeef", data); end
    assertCount++;
    if (memReqCycles !== r0 || writeCycles !== w0) begin
      failCount++;
      $display("[TB] FAIL hit_no_mem: memReq cycles %0d, writes %0d, expected 0/0", memReqCycles - r0, writeCycles - w0);
    end
    assertCount++;
    if (lookupCount !== l0 + 1 || lookupAddr !== 32'h0000_1004) begin
      failCount++;
      $display("[TB] FAIL hit_lookup: %0d lookups at %h, expected 1 at 00001004", lookupCount - l0, lookupAddr);
    end
  endtask

  task automatic test_miss_zero_wait();
    int lat; logic [31:0] data; int w0, r0;
    for (int i = 0; i < 8; i++) memImage[32'h2000 + 32'(i * 4)] = 32'h100 + 32'(i);
    memWait = 0;
    memAddrLog.delete();
    w0 = writeCycles; r0 = memReqCycles;
    doFetch(32'h0000_2018, 1'b0, 32'hFFFF_FFFF, lat, data);
    assertCount++;
    if (lat !== 11) begin failCount++; $display("[TB] FAIL miss_latency: got %0d, expected 11", lat); end
    assertCount++;
    if (data !== 32'h106) begin failCount++; $display("[TB] FAIL miss_data: got %h, expected 00000106", data); end
    assertCount++;
    if (memAddrLog.size() !== 8) begin
      failCount++; $display("[TB] FAIL miss_ack_count: got %0d, expected 8", memAddrLog.size());
    end
    for (int i = 0; i < 8 && i < memAddrLog.size(); i++) begin
      assertCount++;
      if (memAddrLog[i] !== 32'h2000 + 32'(i * 4)) begin
        failCount++;
        $display("[TB] FAIL miss_mem_addr[%0d]: got %h, expected %h", i, memAddrLog[i], 32'h2000 + 32'(i * 4));
      end
    end
    assertCount++;
    if (memReqCycles - r0 !== 8) begin
      failCount++; $display("[TB] FAIL miss_mem_req_cycles: got %0d, expected 8", memReqCycles - r0);
    end
    assertCount++;
    if (writeCycles - w0 !== 1) begin
      failCount++; $display("[TB] FAIL miss_write_cycles: got %0d, expected 1", writeCycles - w0);
    end
    assertCount++;
    if (lastLine[255:224] !== 32'h107 || lastLine !== expectedLine(32'h2018)) begin
      failCount++; $display("[TB] FAIL miss_line: got %h, expected %h", lastLine, expectedLine(32'h2018));
    end
  endtask

  task automatic test_miss_slow_stray();
    int lat; logic [31:0] data; int w0, r0; bit orderOk;
    memWait = 2;
    memAddrLog.delete();
    w0 = writeCycles; r0 = memReqCycles;
    strayAck = 1'b1;
    repeat (3) @(negedge clk);
    strayAck = 1'b0;
    @(negedge clk);
    #1;
    assertCount++;
    if (memReqCycles !== r0 || bus.cpu_ready !== 1'b0 || memAddrLog.size() !== 0) begin
      failCount++; $display("[TB] FAIL stray_ack_idle: memReq cycles %0d, cpu_ready %b, expected 0/0", memReqCycles - r0, bus.cpu_ready);
    end
    doFetch(32'h0000_2018, 1'b0, 32'h1234_5678, lat, data);
    assertCount++;
    if (lat !== 27) begin failCount++; $display("[TB] FAIL slow_latency: got %0d, expected 27", lat); end
    assertCount++;
    if (data !== 32'h106) begin failCount++; $display("[TB] FAIL slow_data: got %h, expected 00000106", data); end
    orderOk = (memAddrLog.size() == 8);
    for (int i = 0; i < 8 && i < memAddrLog.size(); i++)
      if (memAddrLog[i] !== 32'h2000 + 32'(i * 4)) orderOk = 1'b0;
    assertCount++;
    if (orderOk !== 1'b1) begin
      failCount++; $display("[TB] FAIL slow_mem_addr_order: %0d acks, order ok=%b, expected 8/1", memAddrLog.size(), orderOk);
    end
    assertCount++;
    if (memReqCycles - r0 !== 24) begin
      failCount++; $display("[TB] FAIL slow_mem_req_cycles: got %0d, expected 24", memReqCycles - r0);
    end
    assertCount++;
    if (writeCycles - w0 !== 1 || lastLine !== expectedLine(32'h2018)) begin
      failCount++; $display("[TB] FAIL slow_line: %0d writes, line %h, expected 1 write of %h", writeCycles - w0, lastLine, expectedLine(32'h2018));
    end
    memWait = 0;
  endtask

  task automatic test_reset_mid_refill();
    int lat; logic [31:0] data; int w0; bit seen4;
    memWait = 0;
    memAddrLog.delete();
    w0 = writeCycles;
    seen4 = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_3404; bus.cache_hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      bus.cpu_req = 1'b0;
      if (memAddrLog.size() == 4) begin seen4 = 1'b1; break; end
    end
    assertCount++;
    if (seen4 !== 1'b1) begin failCount++; $display("[TB] FAIL abort_reach_4th_ack: got %0d acks, expected 4", memAddrLog.size()); end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    assertCount++;
    if (writeCycles !== w0 || bus.mem_req !== 1'b0 || bus.cache_read !== 1'b1 || bus.cache_line !== '0) begin
      failCount++;
      $display("[TB] FAIL abort_state: writes %0d mem_req %b cache_read %b, expected 0/0/1 and clear line",
               writeCycles - w0, bus.mem_req, bus.cache_read);
    end
    @(negedge clk);
    rst_n = 1'b1;
    memAddrLog.delete();
    doFetch(32'h0000_3404, 1'b0, 32'h0, lat, data);
    assertCount++;
    if (lat !== 11 || data !== memRead(32'h3404)) begin
      failCount++; $display("[TB] FAIL abort_retry: latency %0d data %h, expected 11 / %h", lat, data, memRead(32'h3404));
    end
    assertCount++;
    if (memAddrLog.size() !== 8 || memAddrLog[0] !== 32'h0000_3400) begin
      failCount++; $display("[TB] FAIL abort_restart_cnt: %0d acks, first %h, expected 8 from 00003400", memAddrLog.size(), memAddrLog[0]);
    end
    assertCount++;
    if (writeCycles - w0 !== 1 || lastLine !== expectedLine(32'h3404)) begin
      failCount++; $display("[TB] FAIL abort_single_write: got %0d writes, expected 1 with full line", writeCycles - w0);
    end
  endtask

  task automatic test_back_to_back();
    int w0; int k2; bit ready1;
    w0 = writeCycles;
    ready1 = 1'b0; k2 = 0;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_5000; bus.cache_hit = 1'b1; bus.cache_data = 32'hAAAA_0001;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin ready1 = 1'b1; k2 = k; break; end
    end
    assertCount++;
    if (ready1 !== 1'b1 || k2 !== 2 || bus.cpu_data !== 32'hAAAA_0001) begin
      failCount++; $display("[TB] FAIL b2b_first: ready at %0d data %h, expected 2 / aaaa0001", k2, bus.cpu_data);
    end
    bus.cpu_addr = 32'h0000_6008; bus.cache_data = 32'hBBBB_0002;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    assertCount++;
    if (bus.cache_enable !== 1'b1 || bus.cache_compare !== 1'b1 || bus.cache_address !== 32'h0000_6008) begin
      failCount++;
      $display("[TB] FAIL b2b_second_lookup: enable %b compare %b addr %h, expected 1/1/00006008",
               bus.cache_enable, bus.cache_compare, bus.cache_address);
    end
    @(negedge clk);
    assertCount++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_data !== 32'hBBBB_0002) begin
      failCount++; $display("[TB] FAIL b2b_second_data: ready %b data %h, expected 1 / bbbb0002", bus.cpu_ready, bus.cpu_data);
    end
    #1;
    assertCount++;
    if (writeCycles !== w0) begin failCount++; $display("[TB] FAIL b2b_no_write: got %0d writes, expected 0", writeCycles - w0); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] data; int w0, r0; int expLat;
    logic [31:0] addr, hitData, expData; bit hit; bit orderOk;
    for (int n = 0; n < 24; n++) begin
      addr    = 32'h4000_0000 + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
      hit     = 1'($urandom_range(0, 1));
      hitData = $urandom;
      memWait = $urandom_range(0, 3);
      memAddrLog.delete();
      w0 = writeCycles; r0 = memReqCycles;
      doFetch(addr, hit, hitData, lat, data);
      expLat  = hit ? 2 : 3 + 8 * (memWait + 1);
      expData = hit ? hitData : memRead(addr);
      assertCount++;
      if (lat !== expLat || data !== expData) begin
        failCount++;
        $display("[TB] FAIL rand%0d_fetch: addr %h hit %b latency %0d data %h, expected %0d / %h",
                 n, addr, hit, lat, data, expLat, expData);
      end
      orderOk = (memAddrLog.size() == (hit ? 0 : 8));
      for (int i = 0; i < memAddrLog.size(); i++)
        if (memAddrLog[i] !== (addr & 32'hFFFF_FFE0) + 32'(i * 4)) orderOk = 1'b0;
      assertCount++;
      if (orderOk !== 1'b1 || writeCycles - w0 !== (hit ? 0 : 1)) begin
        failCount++;
        $display("[TB] FAIL rand%0d_traffic: %0d acks order ok=%b, %0d writes, expected %0d acks, %0d writes",
                 n, memAddrLog.size(), orderOk, writeCycles - w0, hit ? 0 : 8, hit ? 0 : 1);
      end
      if (!hit) begin
        assertCount++;
        if (lastLine !== expectedLine(addr)) begin
          failCount++; $display("[TB] FAIL rand%0d_line: got %h, expected %h", n, lastLine, expectedLine(addr));
        end
      end
    end
    memWait = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cache_hit = 1'b0; bus.cache_data = '0;
    test_reset();
    test_hit();
    test_miss_zero_wait();
    test_miss_slow_stray();
    test_reset_mid_refill();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
